// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler: two four-phase requesters share the PWM DAC duty input.
// Round-robin arbitration into a small FIFO; the head entry is applied to the
// DAC only on a period boundary so a duty change never lands mid-period.
module pwm_duty_scheduler #(
    parameter int DUTY_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic [DUTY_WIDTH-1:0] duty0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic [DUTY_WIDTH-1:0] duty1,
    output logic                  ack1,
    input  logic                  period_start,
    input  logic                  flush,
    output logic [DUTY_WIDTH-1:0] duty_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  underrun
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} req_state_t;

    logic [1:0]                 req_v;
    logic [1:0][DUTY_WIDTH-1:0] duty_v;
    logic [1:0]                 ack_v;
    req_state_t                 state_q [2];
    req_state_t                 state_d [2];

    logic [1:0]            cand;
    logic [1:0]            grant;
    logic                  rr_ptr;
    logic                  push;
    logic                  pop;
    logic [DUTY_WIDTH-1:0] push_data;

    logic [DUTY_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;

    assign req_v  = {req1, req0};
    assign duty_v = {duty1, duty0};
    assign ack0   = ack_v[0];
    assign ack1   = ack_v[1];

    // Requester FSM state register; reset drops any handshake in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q[0] <= S_IDLE;
            state_q[1] <= S_IDLE;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // Requester FSM next state: enter ACK on a grant, leave when req drops.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:  if (grant[i]) state_d[i] = S_ACK;
                S_ACK:   if (!req_v[i]) state_d[i] = S_IDLE;
                default: state_d[i] = S_IDLE;
            endcase
        end
    end

    // Requester FSM outputs: ack is high for the whole ACK state.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ack_v[i] = (state_q[i] == S_ACK);
        end
    end

    // Arbiter: one grant per cycle, blocked by a full FIFO or a flush.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cand[i] = (state_q[i] == S_IDLE) && req_v[i];
        end
        grant = 2'b00;
        if (!fifo_full && !flush) begin
            case (cand)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign push      = |grant;
    assign push_data = grant[1] ? duty_v[1] : duty_v[0];
    assign pop       = period_start && !fifo_empty && !flush;

    // Round-robin pointer: after any grant, favour the other requester.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 1'b0;
        end else if (flush) begin
            rr_ptr <= 1'b0;
        end else if (push) begin
            rr_ptr <= grant[0];
        end
    end

    // Occupancy after this cycle's push/pop; a simultaneous pair cancels.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // FIFO pointers, count and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            fifo_full  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count      <= count_nxt;
            fifo_empty <= (count_nxt == '0);
            fifo_full  <= (count_nxt == CW'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DAC duty register and sticky underrun, updated on period boundaries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_out <= '0;
            underrun <= 1'b0;
        end else if (flush) begin
            duty_out <= '0;
            underrun <= 1'b0;
        end else if (period_start) begin
            if (fifo_empty) begin
                underrun <= 1'b1;
            end else begin
                duty_out <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Self-checking bench for pwm_duty_scheduler: a table of cycle vectors,
// hand-written corner sequences, then random traffic against a queue model.
module tb_pwm_duty_scheduler;

    localparam int DW    = 12;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, period_start, flush;
    logic [DW-1:0] duty0, duty1;
    logic          ack0, ack1, fifo_empty, fifo_full, underrun;
    logic [DW-1:0] duty_out;

    int checks   = 0;
    int failures = 0;
    bit check_model = 1'b0;

    pwm_duty_scheduler #(.DUTY_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req0         (req0),
        .duty0        (duty0),
        .ack0         (ack0),
        .req1         (req1),
        .duty1        (duty1),
        .ack1         (ack1),
        .period_start (period_start),
        .flush        (flush),
        .duty_out     (duty_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of accepted values plus handshake flags.
    bit            m_ack [2];
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_duty;
    bit            m_under;
    bit            m_rr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ack[0] = 0; m_ack[1] = 0;
        m_q.delete();
        m_duty = '0; m_under = 0; m_rr = 0;
    endfunction

    function automatic void model_step();
        bit full, empty, c0, c1;
        int g;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        c0 = !m_ack[0] && req0;
        c1 = !m_ack[1] && req1;
        g  = -1;
        if (!flush && !full) begin
            if (c0 && c1)  g = m_rr ? 1 : 0;
            else if (c0)   g = 0;
            else if (c1)   g = 1;
        end
        if (m_ack[0] && !req0) m_ack[0] = 0;
        if (m_ack[1] && !req1) m_ack[1] = 0;
        if (flush) begin
            m_q.delete();
            m_duty = '0; m_under = 0; m_rr = 0;
        end else begin
            if (period_start) begin
                if (empty) m_under = 1;
                else       m_duty = m_q.pop_front();
            end
            if (g >= 0) begin
                m_q.push_back(g == 1 ? duty1 : duty0);
                m_ack[g] = 1;
                m_rr = (g == 0);
            end
        end
    endfunction

    task automatic compare_model();
        chk("rnd.ack0", ack0, m_ack[0]);
        chk("rnd.ack1", ack1, m_ack[1]);
        chk("rnd.duty_out", duty_out, m_duty);
        chk("rnd.fifo_empty", fifo_empty, m_q.size() == 0);
        chk("rnd.fifo_full", fifo_full, m_q.size() == DEPTH);
        chk("rnd.underrun", underrun, m_under);
    endtask

    // One clock: inputs already stable, model follows the edge, sample at negedge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (check_model) compare_model();
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; duty0 = '0; duty1 = '0;
        period_start = 0; flush = 0;
        reset_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    function automatic logic cur_ack(input int r);
        return (r == 1) ? ack1 : ack0;
    endfunction

    // Full four-phase handshake for one value on requester r.
    task automatic do_push(input int r, input logic [DW-1:0] v);
        if (r == 1) begin req1 = 1; duty1 = v; end
        else        begin req0 = 1; duty0 = v; end
        for (int n = 0; n < 10 && !cur_ack(r); n++) tick();
        chk($sformatf("push%0d.ack_rise", r), cur_ack(r), 1);
        if (r == 1) req1 = 0; else req0 = 0;
        for (int n = 0; n < 10 && cur_ack(r); n++) tick();
        chk($sformatf("push%0d.ack_fall", r), cur_ack(r), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".ack0"}, ack0, 0);
        chk({tag, ".ack1"}, ack1, 0);
        chk({tag, ".duty_out"}, duty_out, 0);
        chk({tag, ".fifo_empty"}, fifo_empty, 1);
        chk({tag, ".fifo_full"}, fifo_full, 0);
        chk({tag, ".underrun"}, underrun, 0);
    endtask

    typedef struct {
        bit            rst_before;
        bit            r0;
        logic [DW-1:0] d0;
        bit            r1;
        logic [DW-1:0] d1;
        bit            ps;
        bit            fl;
        bit            e_ack0;
        bit            e_ack1;
        logic [DW-1:0] e_duty;
        bit            e_empty;
        bit            e_full;
        bit            e_ur;
    } vec_t;

    function automatic vec_t mk(bit rst, bit r0, logic [DW-1:0] d0, bit r1, logic [DW-1:0] d1,
                                bit ps, bit fl, bit a0, bit a1, logic [DW-1:0] dout,
                                bit emp, bit ful, bit ur);
        vec_t v;
        v.rst_before = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1;
        v.ps = ps; v.fl = fl; v.e_ack0 = a0; v.e_ack1 = a1; v.e_duty = dout;
        v.e_empty = emp; v.e_full = ful; v.e_ur = ur;
        return v;
    endfunction

    initial begin
        vec_t tbl [$];

        //          rst r0 d0      r1 d1      ps fl  a0 a1 dout    emp ful ur
        tbl.push_back(mk(1, 1, 12'h000, 0, 12'h000, 0, 0, 1, 0, 12'h000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 12'h000, 1, 0, 0));
        tbl.push_back(mk(1, 1, 12'h100, 1, 12'h200, 0, 0, 1, 0, 12'h000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 12'h100, 1, 12'h200, 0, 0, 1, 1, 12'h000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 12'h000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 12'h100, 0, 0, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 12'h200, 1, 0, 0));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 1, 0, 0, 0, 12'h200, 1, 0, 1));
        tbl.push_back(mk(0, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0, 12'h200, 1, 0, 1));

        do_reset();
        chk_reset_state("reset");

        // Table: basic handshake, tie-break, ordered pops and underrun.
        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            req0 = tbl[i].r0; duty0 = tbl[i].d0;
            req1 = tbl[i].r1; duty1 = tbl[i].d1;
            period_start = tbl[i].ps; flush = tbl[i].fl;
            tick();
            chk($sformatf("vec%0d.ack0", i), ack0, tbl[i].e_ack0);
            chk($sformatf("vec%0d.ack1", i), ack1, tbl[i].e_ack1);
            chk($sformatf("vec%0d.duty_out", i), duty_out, tbl[i].e_duty);
            chk($sformatf("vec%0d.fifo_empty", i), fifo_empty, tbl[i].e_empty);
            chk($sformatf("vec%0d.fifo_full", i), fifo_full, tbl[i].e_full);
            chk($sformatf("vec%0d.underrun", i), underrun, tbl[i].e_ur);
        end

        // Full FIFO blocks a fifth push until a pop frees a slot; wrap order.
        do_reset();
        do_push(0, 12'h001); do_push(1, 12'h002);
        do_push(0, 12'h003); do_push(1, 12'h004);
        chk("full.after4", fifo_full, 1);
        req1 = 1; duty1 = 12'h005;
        tick(); tick();
        chk("full.fifth_blocked", ack1, 0);
        period_start = 1; tick(); period_start = 0;
        chk("full.pop1", duty_out, 12'h001);
        chk("full.cleared", fifo_full, 0);
        chk("full.fifth_wait", ack1, 0);
        tick();
        chk("full.fifth_acked", ack1, 1);
        chk("full.refilled", fifo_full, 1);
        req1 = 0; tick();
        chk("full.ack1_fall", ack1, 0);
        for (int k = 2; k <= 5; k++) begin
            period_start = 1; tick(); period_start = 0;
            chk($sformatf("wrap.pop%0d", k), duty_out, k);
        end
        chk("wrap.empty", fifo_empty, 1);

        // Simultaneous push and pop at count 2.
        do_push(0, 12'h00A); do_push(1, 12'h00B);
        req0 = 1; duty0 = 12'h00C; period_start = 1;
        tick();
        period_start = 0;
        chk("pp.head", duty_out, 12'h00A);
        chk("pp.ack0", ack0, 1);
        chk("pp.not_empty", fifo_empty, 0);
        chk("pp.not_full", fifo_full, 0);
        req0 = 0; tick();
        period_start = 1; tick();
        chk("pp.pop2", duty_out, 12'h00B);
        tick();
        chk("pp.pop3", duty_out, 12'h00C);
        chk("pp.empty", fifo_empty, 1);
        tick();
        period_start = 0;
        chk("pp.underrun", underrun, 1);
        chk("pp.held", duty_out, 12'h00C);

        // Flush with ack1 high and a competing request on requester 0.
        do_push(0, 12'h00D); do_push(1, 12'h00E);
        req1 = 1; duty1 = 12'h00F; tick();
        chk("fl.ack1_up", ack1, 1);
        req0 = 1; duty0 = 12'h011; flush = 1;
        tick();
        flush = 0;
        chk("fl.empty", fifo_empty, 1);
        chk("fl.duty_out", duty_out, 0);
        chk("fl.underrun", underrun, 0);
        chk("fl.no_grant", ack0, 0);
        chk("fl.ack1_held", ack1, 1);
        tick();
        chk("fl.grant_after", ack0, 1);
        chk("fl.ack1_still", ack1, 1);
        req1 = 0; tick();
        chk("fl.ack1_fall", ack1, 0);
        req0 = 0; tick();
        chk("fl.ack0_fall", ack0, 0);

        // Asynchronous reset in the middle of a handshake.
        period_start = 1; tick();
        chk("ar.pop", duty_out, 12'h011);
        tick();
        period_start = 0;
        chk("ar.underrun", underrun, 1);
        req0 = 1; duty0 = 12'h022; tick();
        chk("ar.ack0", ack0, 1);
        chk("ar.not_empty", fifo_empty, 0);
        #2 reset_n = 0;
        #1 chk_reset_state("async_reset");
        do_reset();

        // Random protocol-legal traffic against the queue model.
        check_model = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!req0 && !m_ack[0] && $urandom_range(0, 2) == 0) begin
                req0 = 1; duty0 = DW'($urandom);
            end else if (req0 && m_ack[0] && $urandom_range(0, 2) == 0) begin
                req0 = 0;
            end
            if (!req1 && !m_ack[1] && $urandom_range(0, 2) == 0) begin
                req1 = 1; duty1 = DW'($urandom);
            end else if (req1 && m_ack[1] && $urandom_range(0, 2) == 0) begin
                req1 = 0;
            end
            period_start = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 60) == 0);
            tick();
        end
        check_model = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
